// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector over a raster pixel stream.
// Two line buffers plus a 3x3 window feed a 3-stage pipeline:
// S1 window load, S2 Gx/Gy, S3 |Gx|+|Gy| with per-frame mode select.
module sobel_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100,
    parameter int THRESH = 128
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              pi_flag,
    input  logic [DATA_W-1:0] pi_data,
    input  logic              mode,
    output logic              po_flag,
    output logic [DATA_W-1:0] po_data,
    output logic              frame_done
);
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int GW     = DATA_W + 3;
    localparam int STAGES = 3;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          mode_q, mode_d;

    logic [STAGES-1:0] vld_pipe_q;   // [0]=window, [1]=Gx/Gy, [2]=output
    logic [STAGES-1:0] fd_pipe_q;
    logic [1:0]        md_pipe_q;    // frame mode travelling with the data

    logic [DATA_W-1:0] lb1_q [IMG_W];  // row-1
    logic [DATA_W-1:0] lb2_q [IMG_W];  // row-2
    logic [DATA_W-1:0] lb1_rd, lb2_rd;

    // window rows: w0 oldest (row-2), w2 newest; index 2 = newest column
    logic [2:0][DATA_W-1:0] w0_q, w1_q, w2_q;

    logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic [GW-1:0]        ax, ay, mag;
    logic [DATA_W-1:0]    res_d, po_data_q;
    logic                 qual, last_px;

    function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
        return signed'({3'b000, p});
    endfunction

    assign lb1_rd  = lb1_q[col_q];
    assign lb2_rd  = lb2_q[col_q];
    assign qual    = pi_flag && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_px = pi_flag && (row_q == ROW_LAST) && (col_q == COL_LAST);

    // raster position and frame-mode latch, advancing only on accepted pixels
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        mode_d = mode_q;
        if (pi_flag) begin
            if (col_q == '0 && row_q == '0)
                mode_d = mode;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // line buffers shift one row down per accepted pixel; contents never cleared
    always_ff @(posedge sys_clk) begin
        if (pi_flag) begin
            lb1_q[col_q] <= pi_data;
            lb2_q[col_q] <= lb1_rd;
        end
    end

    // S1: 3x3 window shift on accepted pixels
    always_ff @(posedge sys_clk) begin
        if (pi_flag) begin
            w0_q <= {lb2_rd,  w0_q[2:1]};
            w1_q <= {lb1_rd,  w1_q[2:1]};
            w2_q <= {pi_data, w2_q[2:1]};
        end
    end

    // S2 combinational: gradients, right-minus-left and bottom-minus-top
    always_comb begin
        gx_d = (ext(w0_q[2]) + (ext(w1_q[2]) <<< 1) + ext(w2_q[2]))
             - (ext(w0_q[0]) + (ext(w1_q[0]) <<< 1) + ext(w2_q[0]));
        gy_d = (ext(w2_q[0]) + (ext(w2_q[1]) <<< 1) + ext(w2_q[2]))
             - (ext(w0_q[0]) + (ext(w0_q[1]) <<< 1) + ext(w0_q[2]));
    end

    // S2 register: data moves every cycle, validity is tracked separately
    always_ff @(posedge sys_clk) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
    end

    // S3 combinational: magnitude and saturate/threshold by the frame's mode
    always_comb begin
        ax  = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
        ay  = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
        mag = ax + ay;
        if (md_pipe_q[1])
            res_d = (|mag[GW-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
        else
            res_d = (mag >= GW'(THRESH)) ? '1 : '0;
    end

    // control state: counters, mode latch, valid pipeline, output register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            col_q      <= '0;
            row_q      <= '0;
            mode_q     <= 1'b0;
            vld_pipe_q <= '0;
            fd_pipe_q  <= '0;
            md_pipe_q  <= '0;
            po_data_q  <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            mode_q     <= mode_d;
            vld_pipe_q <= {vld_pipe_q[STAGES-2:0], qual};
            fd_pipe_q  <= {fd_pipe_q[STAGES-2:0], last_px};
            md_pipe_q  <= {md_pipe_q[0], mode_q};
            if (vld_pipe_q[1])
                po_data_q <= res_d;
        end
    end

    assign po_flag    = vld_pipe_q[STAGES-1];
    assign frame_done = fd_pipe_q[STAGES-1];
    assign po_data    = po_data_q;
endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on an 8x8 frame.
// Expected outputs come from a direct 3x3 kernel convolution of the frame.
module tb_sobel_stream;
    localparam int W = 8, H = 8, DW = 8, TH = 128;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          pi_flag = 1'b0;
    logic [DW-1:0] pi_data = '0;
    logic          mode    = 1'b0;
    logic          po_flag, frame_done;
    logic [DW-1:0] po_data;

    sobel_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .THRESH(TH)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_flag(pi_flag), .pi_data(pi_data),
        .mode(mode), .po_flag(po_flag), .po_data(po_data), .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] val;
        int         stamp;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0, miscompares = 0, n_out = 0, n_fd = 0;
    int   img[H][W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Sobel by kernel convolution around centre (r,c)
    function automatic logic [7:0] ref_px(input int r, input int c, input bit md);
        int kx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        int gx = 0, gy = 0, mag;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                gx += kx[i][j] * img[r-1+i][c-1+j];
                gy += kx[j][i] * img[r-1+i][c-1+j];
            end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (md) return (mag > 255) ? 8'hFF : 8'(mag);
        return (mag >= TH) ? 8'hFF : 8'h00;
    endfunction

    function automatic void fill_flat(input int v);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
    endfunction

    function automatic void fill_step();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 255 : 0;
    endfunction

    function automatic void fill_rand();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(255, 0));
    endfunction

    // output monitor
    always @(negedge sys_clk) begin
        if (po_flag === 1'b1) begin
            n_out++;
            if (frame_done === 1'b1) n_fd++;
            if (exp_q.size() == 0) begin
                chk("unexpected_po", 32'(po_flag), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("po_data", 32'(po_data), 32'(e.val));
                chk("latency", 32'(cyc), 32'(e.stamp + 3));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
            end
        end else if (frame_done !== 1'b0) begin
            chk("fd_without_po", 32'(frame_done), 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            pi_flag = 1'b0;
        end
    endtask

    // drives npix pixels of img; expectations only for a complete frame
    task automatic send_frame(input bit md0, input int tog_at, input bit md1,
                              input int gap, input bit rnd, input int npix);
        for (int i = 0; i < npix; i++) begin
            int r, c, g;
            r = i / W;
            c = i % W;
            g = rnd ? int'($urandom_range(gap, 0)) : gap;
            if (i > 0) idle(g);
            @(negedge sys_clk);
            pi_flag = 1'b1;
            pi_data = 8'(img[r][c]);
            mode    = (i >= tog_at) ? md1 : md0;
            if (npix == W*H && r >= 2 && c >= 2)
                exp_q.push_back(exp_t'{ref_px(r-1, c-1, md0), cyc, (r == H-1 && c == W-1)});
        end
    endtask

    task automatic frame_check(input string tag, input int bo, input int bf,
                               input int nexp, input int nfd);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        idle(4);
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_count"}, 32'(n_out - bo), 32'(nexp));
        chk({tag, "_fdcnt"}, 32'(n_fd - bf), 32'(nfd));
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        pi_flag = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        int bo, bf;
        repeat (3) @(negedge sys_clk);
        chk("rst_po_flag", 32'(po_flag), 32'd0);
        chk("rst_po_data", 32'(po_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        sys_rst = 1'b0;
        idle(2);

        // flat frame, magnitude then binary
        fill_flat(8'h80);
        bo = n_out; bf = n_fd; send_frame(1, 64, 1, 0, 0, 64); frame_check("flat_m1", bo, bf, 36, 1);
        bo = n_out; bf = n_fd; send_frame(0, 64, 0, 0, 0, 64); frame_check("flat_m0", bo, bf, 36, 1);

        // vertical step, both modes, then with pi_flag every 3rd cycle
        fill_step();
        bo = n_out; bf = n_fd; send_frame(1, 64, 1, 0, 0, 64); frame_check("step_m1", bo, bf, 36, 1);
        bo = n_out; bf = n_fd; send_frame(0, 64, 0, 0, 0, 64); frame_check("step_m0", bo, bf, 36, 1);
        bo = n_out; bf = n_fd; send_frame(1, 64, 1, 2, 0, 64); frame_check("step_gap", bo, bf, 36, 1);

        // mode change mid-frame ignored until next frame
        fill_rand();
        bo = n_out; bf = n_fd; send_frame(0, 30, 1, 0, 0, 64); frame_check("tog_bin", bo, bf, 36, 1);
        fill_rand();
        bo = n_out; bf = n_fd; send_frame(1, 64, 1, 0, 0, 64); frame_check("tog_mag", bo, bf, 36, 1);

        // aborted frame, then clean flat frame
        fill_step();
        bo = n_out; bf = n_fd;
        send_frame(1, 64, 1, 0, 0, 20);
        do_reset();
        fill_flat(8'h80);
        send_frame(1, 64, 1, 0, 0, 64);
        frame_check("abort", bo, bf, 36, 1);

        // two back-to-back frames without an idle cycle
        bo = n_out; bf = n_fd;
        fill_rand(); send_frame(1, 64, 1, 0, 0, 64);
        fill_rand(); send_frame(0, 64, 0, 0, 0, 64);
        frame_check("b2b", bo, bf, 72, 2);

        // random frames with random gaps and modes
        for (int k = 0; k < 3; k++) begin
            bit md;
            md = 1'($urandom_range(1, 0));
            fill_rand();
            bo = n_out; bf = n_fd;
            send_frame(md, 64, md, 3, 1, 64);
            frame_check("rand", bo, bf, 36, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
